// File: rtl/i2c_byte_transmitter.sv
// Write-only I2C byte engine paced by an external slow-clock generator's strobes.
// Optional feature: define I2C_NACK_ABORT_EN to force a STOP after a NACK.
module i2c_byte_transmitter #(
  parameter int I2C_DATA_WIDTH = 8,
  parameter int I2C_CNT_BITS   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk_in,
  input  logic                      rising_edge,
  input  logic                      falling_edge,
  input  logic                      middle_of_high_level,
  input  logic                      middle_of_low_level,
  input  logic                      start_transfer,
  input  logic                      send_start_bit,
  input  logic                      send_stop_bit,
  input  logic [I2C_DATA_WIDTH-1:0] data_in,
  output logic                      i2c_sclk,
  inout  wire                       i2c_sdata,
  output logic                      busy,
  output logic                      transfer_complete,
  output logic                      ack_error
);

  typedef enum logic [2:0] {IDLE, START, TX_BIT, ACK, STOP, DONE} state_t;

  state_t                    state, state_next;
  logic [I2C_DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [I2C_CNT_BITS-1:0]   bit_cnt, cnt_next;
  logic                      start_flag, start_flag_next;
  logic                      stop_flag, stop_flag_next;
  logic                      sda_low, sda_low_next;
  logic                      sclk_next, busy_next, tc_next, ack_error_next;
  logic                      seen_mid_high, seen_next;
  logic                      stop_rose, stop_rose_next;

  // Open-drain: only ever pull low or let the bus float high.
  assign i2c_sdata = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      shift_reg         <= '0;
      bit_cnt           <= '0;
      start_flag        <= 1'b0;
      stop_flag         <= 1'b0;
      sda_low           <= 1'b0;
      i2c_sclk          <= 1'b1;
      busy              <= 1'b0;
      transfer_complete <= 1'b0;
      ack_error         <= 1'b0;
      seen_mid_high     <= 1'b0;
      stop_rose         <= 1'b0;
    end else begin
      state             <= state_next;
      shift_reg         <= shift_next;
      bit_cnt           <= cnt_next;
      start_flag        <= start_flag_next;
      stop_flag         <= stop_flag_next;
      sda_low           <= sda_low_next;
      i2c_sclk          <= sclk_next;
      busy              <= busy_next;
      transfer_complete <= tc_next;
      ack_error         <= ack_error_next;
      seen_mid_high     <= seen_next;
      stop_rose         <= stop_rose_next;
    end
  end

  always_comb begin
    state_next      = state;
    shift_next      = shift_reg;
    cnt_next        = bit_cnt;
    start_flag_next = start_flag;
    stop_flag_next  = stop_flag;
    sda_low_next    = sda_low;
    ack_error_next  = ack_error;
    seen_next       = seen_mid_high;
    stop_rose_next  = stop_rose;
    sclk_next       = 1'b1;

    case (state)
      IDLE: begin
        sda_low_next = 1'b0;
        if (start_transfer) begin
          shift_next      = data_in;
          start_flag_next = send_start_bit;
          stop_flag_next  = send_stop_bit;
          cnt_next        = I2C_CNT_BITS'(I2C_DATA_WIDTH);
          ack_error_next  = 1'b0;
          seen_next       = 1'b0;
          state_next      = START;
        end
      end

      // Leave only on a falling edge that follows a mid-high seen here.
      START: begin
        if (middle_of_high_level) begin
          seen_next = 1'b1;
          if (start_flag) sda_low_next = 1'b1;
        end
        if (falling_edge && seen_mid_high) state_next = TX_BIT;
      end

      TX_BIT: begin
        sclk_next = sclk_in;
        if (middle_of_low_level) begin
          sda_low_next = ~shift_reg[I2C_DATA_WIDTH-1];
          shift_next   = {shift_reg[I2C_DATA_WIDTH-2:0], 1'b0};
          cnt_next     = bit_cnt - 1'b1;
        end
        if (falling_edge && bit_cnt == '0) state_next = ACK;
      end

      ACK: begin
        sclk_next = sclk_in;
        if (middle_of_low_level) sda_low_next = 1'b0;
        if (middle_of_high_level) ack_error_next = i2c_sdata;
        if (falling_edge) begin
          stop_rose_next = 1'b0;
`ifdef I2C_NACK_ABORT_EN
          state_next = (stop_flag || ack_error) ? STOP : DONE;
`else
          state_next = stop_flag ? STOP : DONE;
`endif
        end
      end

      // SCL is parked high after the first rising edge so SDA can rise under it.
      STOP: begin
        sclk_next = (stop_rose || rising_edge) ? 1'b1 : sclk_in;
        if (middle_of_low_level && !stop_rose) sda_low_next = 1'b1;
        if (rising_edge) stop_rose_next = 1'b1;
        if (middle_of_high_level && stop_rose) begin
          sda_low_next = 1'b0;
          state_next   = DONE;
        end
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
    tc_next   = (state_next == DONE);
  end

endmodule
